// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: shared ALU op codes, request op codes, FSM states and flag bit indices
package alu_sequencer_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_OR  = 3'b001,
    ALU_XOR = 3'b010,
    ALU_AND = 3'b011,
    ALU_SR  = 3'b100,
    ALU_SL  = 3'b101
  } alu_op_e;
  typedef enum logic [3:0] {
    OP_ADC = 4'd0,
    OP_SBC = 4'd1,
    OP_AND = 4'd2,
    OP_ORA = 4'd3,
    OP_EOR = 4'd4,
    OP_ASL = 4'd5,
    OP_LSR = 4'd6,
    OP_ROL = 4'd7,
    OP_ROR = 4'd8,
    OP_CMP = 4'd9
  } req_op_e;
  typedef enum logic [2:0] {S_IDLE, S_P1, S_P2, S_P3, S_DONE} state_e;
  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_V = 6;
  localparam int P_N = 7;
  localparam int F_C = 0;
  localparam int F_Z = 1;
  localparam int F_V = 2;
  localparam int F_N = 3;
endpackage

// File: rtl/alu_sequencer_bcd_adjust.sv
// alu_sequencer_bcd_adjust: nibble half-carry and decimal correction enables/constants for ADC and SBC
module alu_sequencer_bcd_adjust (
  input  logic [3:0] a_lo,
  input  logic [3:0] b_lo,
  input  logic       cin,
  input  logic       sub,
  input  logic [7:0] bin_y,
  input  logic       bin_c,
  output logic       lo_en,
  output logic       hi_en,
  output logic [7:0] lo_k,
  output logic [7:0] hi_k
);
  logic [4:0] nib;
  assign nib = {1'b0, a_lo} + {1'b0, sub ? ~b_lo : b_lo} + {4'b0, cin};
  assign lo_en = sub ? ~nib[4] : nib > 5'd9;
  assign hi_en = sub ? ~bin_c : bin_y > 8'h99 || bin_c;
  assign lo_k = sub ? 8'hFA : 8'h06;
  assign hi_k = sub ? 8'hA0 : 8'h60;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences a single-pass ALU through multi-pass 6502 ops (SBC, CMP, rotates, decimal ADC/SBC)
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter logic DEC_EN = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic       req_c,
  input  logic       req_d,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_y,
  output logic [3:0] rsp_flags,
  output logic       rsp_err,
  output logic [2:0] alu_ctrl,
  output logic [7:0] alu_ai,
  output logic [7:0] alu_bi,
  output logic       alu_cin,
  input  logic [7:0] alu_y,
  input  logic       alu_cout,
  input  logic       alu_vout
);
  state_e st, nxt;
  logic [3:0] op_r, b_lo_r;
  logic [7:0] a_r, lo_k, hi_k, bi_p1;
  logic [2:0] ctrl_p1;
  logic c_r, dec_r, hi_r, cy_r, v_r, c_n, v_n, cin_p1;
  logic lo_en, hi_en, rot, arith, pass, accept;
  alu_sequencer_bcd_adjust u_bcd (
    .a_lo  (a_r[3:0]),
    .b_lo  (b_lo_r),
    .cin   (c_r),
    .sub   (op_r == OP_SBC),
    .bin_y (alu_y),
    .bin_c (alu_cout),
    .lo_en (lo_en),
    .hi_en (hi_en),
    .lo_k  (lo_k),
    .hi_k  (hi_k)
  );
  assign req_ready = st == S_IDLE;
  assign accept = req_valid && req_ready;
  assign rot = op_r == OP_ROL || op_r == OP_ROR;
  assign arith = op_r == OP_ADC || op_r == OP_SBC;
  assign pass = st == S_P1 || st == S_P2 || st == S_P3;
  always_comb begin
    nxt = st == S_IDLE ? (accept ? (req_op <= OP_CMP ? S_P1 : S_DONE) : S_IDLE)
        : st == S_P1 ? ((rot || (dec_r && lo_en)) ? S_P2 : (dec_r && hi_en) ? S_P3 : S_DONE)
        : st == S_P2 ? (hi_r ? S_P3 : S_DONE)
        : st == S_P3 ? S_DONE
        : rsp_ready ? S_IDLE : S_DONE;
    ctrl_p1 = req_op == OP_AND ? ALU_AND : req_op == OP_ORA ? ALU_OR : req_op == OP_EOR ? ALU_XOR
            : (req_op == OP_ASL || req_op == OP_ROL) ? ALU_SL
            : (req_op == OP_LSR || req_op == OP_ROR) ? ALU_SR : ALU_ADD;
    bi_p1 = (req_op == OP_SBC || req_op == OP_CMP) ? ~req_b : req_b;
    cin_p1 = req_op == OP_CMP || (req_op <= OP_SBC && req_c);
    // carry: add chain on P1, shifted-out bit for shifts, forced by the decimal high adjust
    c_n = st == S_P1 ? ((arith || op_r == OP_CMP) ? alu_cout
                        : (op_r == OP_ASL || op_r == OP_ROL) ? a_r[7]
                        : (op_r == OP_LSR || op_r == OP_ROR) ? a_r[0] : c_r)
        : st == S_P3 ? op_r == OP_ADC : cy_r;
    v_n = st == S_P1 ? arith && alu_vout : v_r;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      st <= S_IDLE;
      op_r <= '0;
      a_r <= '0;
      b_lo_r <= '0;
      c_r <= 1'b0;
      dec_r <= 1'b0;
      hi_r <= 1'b0;
      cy_r <= 1'b0;
      v_r <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_y <= '0;
      rsp_flags <= '0;
      rsp_err <= 1'b0;
      alu_ctrl <= ALU_ADD;
      alu_ai <= '0;
      alu_bi <= '0;
      alu_cin <= 1'b0;
    end else begin
      st <= nxt;
      if (accept) begin
        op_r <= req_op;
        a_r <= req_a;
        b_lo_r <= req_b[3:0];
        c_r <= req_c;
        dec_r <= DEC_EN && req_d && (req_op <= OP_SBC);
        rsp_err <= nxt == S_DONE;
        alu_ctrl <= ctrl_p1;
        alu_ai <= req_a;
        alu_bi <= bi_p1;
        alu_cin <= cin_p1;
      end
      if (accept && nxt == S_DONE) begin
        rsp_valid <= 1'b1;
        rsp_y <= req_a;
        rsp_flags <= '0;
      end
      if (pass) begin
        cy_r <= c_n;
        v_r <= v_n;
      end
      if (st == S_P1)
        hi_r <= dec_r && hi_en;
      // next pass always works on the byte just produced
      if (pass && nxt != S_DONE) begin
        alu_ctrl <= (nxt == S_P2 && rot) ? ALU_OR : ALU_ADD;
        alu_ai <= alu_y;
        alu_bi <= nxt == S_P3 ? hi_k : !rot ? lo_k : op_r == OP_ROL ? {7'b0, c_r} : {c_r, 7'b0};
        alu_cin <= 1'b0;
      end
      if (pass && nxt == S_DONE) begin
        rsp_valid <= 1'b1;
        rsp_y <= op_r == OP_CMP ? a_r : alu_y;
        rsp_flags[F_N] <= alu_y[7];
        rsp_flags[F_V] <= v_n;
        rsp_flags[F_Z] <= alu_y == 8'h00;
        rsp_flags[F_C] <= c_n;
      end
      if (st == S_DONE && rsp_ready)
        rsp_valid <= 1'b0;
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-pass controller that owns the ALU datapath (ops ADD/OR/XOR/AND/SR/SL) and sequences it for full 6502 arithmetic/logic instructions.
- Handles ops the ALU cannot finish in one pass: SBC, CMP, rotates and decimal-mode ADC/SBC.
- Sits between the decode/execute FSM (request/response handshake) and the ALU instance, and produces final result plus N V Z C flags.

Parameters:
- DEC_EN, 1, 1 = decimal-mode correction passes enabled; 0 = D flag ignored (binary only).

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept (IDLE only)
- req_op  in  4  ADC=0 SBC=1 AND=2 ORA=3 EOR=4 ASL=5 LSR=6 ROL=7 ROR=8 CMP=9; others illegal
- req_a  in  8  operand A (accumulator / RMW operand)
- req_b  in  8  operand B (memory operand)
- req_c  in  1  incoming carry flag
- req_d  in  1  decimal flag
- rsp_valid  out  1  result/flags valid
- rsp_ready  in  1  consumer accepts response
- rsp_y  out  8  result byte
- rsp_flags  out  4  {N,V,Z,C}
- rsp_err  out  1  illegal op
- alu_ctrl  out  3  ALU op (ADD 000, OR 001, XOR 010, AND 011, SR 100, SL 101)
- alu_ai, alu_bi  out  8 each  ALU operands
- alu_cin  out  1  ALU carry in
- alu_y  in  8  ALU result
- alu_cout  in  1  ALU carry out
- alu_vout  in  1  ALU overflow

Behaviour:
- Reset (async, resetn low): state IDLE; req_ready=1 after release; rsp_valid=0, rsp_y=0, rsp_flags=0, rsp_err=0, alu_ctrl=ADD, alu_ai/bi=0, alu_cin=0. Reset mid-operation aborts the pass; no response is produced.
- Accept on rising edge with req_valid&&req_ready; operands latched. req_ready=0 outside IDLE.
- States: IDLE -> P1 -> [P2] -> [P3] -> DONE -> IDLE. One ALU pass per cycle. alu_y/alu_cout/alu_vout captured at the end of each pass. Latency = number of passes; rsp_valid rises the cycle after the last capture.
- DONE holds rsp_* stable until rsp_valid&&rsp_ready, then IDLE. req_ready rises the cycle after that handshake. No back-to-back accept.
- P1 mapping:
  - ADC: ADD(a,b,c)
  - SBC: ADD(a,~b,c)
  - CMP: ADD(a,~b,1)
  - AND/ORA/EOR: AND/OR/XOR(a,b)
  - ASL/ROL: SL(a)
  - LSR/ROR: SR(a)
- P2 for rotates: ROL = OR(y1, {7'b0,c}); ROR = OR(y1, {c,7'b0}). C = shifted-out bit from P1.
- Decimal (DEC_EN=1, req_d=1, ADC/SBC only):
  - During P1, compute local 5-bit nibble sum/difference of a[3:0], b[3:0] (or ~b[3:0]) and c.
  - P2, low adjust: ADC runs if nibble >9 or half-carry; adds 0x06. SBC runs if half-borrow; adds 0xFA. Otherwise P2 is skipped.
  - P3, high adjust: ADC runs if the binary result >0x99 or P1 carry; adds 0x60 and forces C=1. SBC runs if P1 carry=0; adds 0xA0 and forces C=0.
  - V comes from P1. N/Z come from the final byte.
- Flags:
  - Z = (final y==0). N = y[7].
  - V: valid for ADC/SBC only; 0 otherwise.
  - C: ADC/SBC/CMP from the add chain. Shifts from the shifted-out bit. Logic ops pass req_c through unchanged.
- CMP: rsp_y = req_a (unchanged); flags per subtraction.
- Illegal op: no ALU pass. Go straight to DONE with rsp_err=1, rsp_y=req_a, flags=0.
- While IDLE, ALU drive holds last values; ALU outputs are ignored.

Decomposition:
- Shared params include holds the ALU op codes, req_op codes, and flag bit indices (C=0, Z=1, V=6, N=7, plus the 4-bit rsp_flags ordering).
- One natural sub-module: bcd_adjust. It is combinational and computes the nibble sum/half-carry and the P2/P3 correction constants and enables. It is reused by ADC and SBC.

Test Plan:
- ADC binary: a=0x50, b=0x50, c=0, d=0 -> 1 pass; y=0xA0, N=1, V=1, Z=0, C=0; rsp_valid 2nd cycle after accept.
- SBC/CMP: SBC a=0x10, b=0x20, c=1 -> y=0xF0, C=0, N=1. CMP a=0x40, b=0x40 -> y=0x40, Z=1, C=1.
- ROL/ROR: ROL a=0x81, c=1 -> 2 passes; y=0x03, C=1. ROR a=0x01, c=0 -> y=0x00, Z=1, C=1.
- Decimal ADC: a=0x58, b=0x46, c=1, d=1 -> 3 passes; y=0x05, C=1. Decimal SBC: a=0x40, b=0x13, c=1, d=1 -> y=0x27, C=1.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0; new req_valid ignored until the handshake completes.
- Reset mid-op: assert resetn=0 during P2 of decimal ADC -> all outputs at reset values immediately; after release, the next request completes normally; illegal op 0xF -> rsp_err=1.
